arbiter_4ne1: RTL and testbench
===============================

// Module: arbiter_4ne1
// PURPOSE
// - Round-robin arbiter/controller for the shared 4:1 select path in the 24-bit single-cycle CPU.
// - Four requesters compete for one shared resource; the winner's index drives the 2-bit select S of the 4:1 mux.
// - Grant is held until the owner releases it. Fair rotation prevents starvation.
// PARAMETERS
// - MAX_HOLD  16  max consecutive BUSY cycles per grant; legal range 2..255; used only with ARB_TIMEOUT_EN
// PORTS
// - Clock    in   1  single clock; all state updates on rising edge
// - Reset_n  in   1  synchronous reset, active-low; sampled on rising edge of Clock
// - Kerkesa  in   4  request vector; bit i = requester i
// - Leja     out  4  one-hot grant; 0 when idle
// - S        out  2  binary index of current owner; feeds the 4:1 mux select
// - Valid    out  1  1 while a grant is active (Valid == |Leja)
// - Timeout  out  1  one-cycle pulse when a grant is force-released; 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
// - Reset (Reset_n=0 at edge): Leja=0, S=2'b00, Valid=0, Timeout=0, state=IDLE, ptr=0, hold_cnt=0.
// - Reset has priority over every other event and aborts any active grant in that same edge.
// - FSM state IDLE:
//   - If Kerkesa!=0, pick the first set bit scanning ptr, ptr+1, ... (mod 4).
//   - Next edge: Leja=onehot(w), S=w, Valid=1, state=BUSY, hold_cnt=0.
//   - If Kerkesa==0, stay in IDLE with outputs 0.
//   - Request-to-grant latency is 1 cycle.
// - FSM state BUSY:
//   - If Kerkesa[S]==1, keep the grant and increment hold_cnt.
//   - If Kerkesa[S]==0, next edge: Leja=0, Valid=0, state=IDLE, ptr=S+1 (2-bit wrap, 3->0).
//   - Other requesters' bits are ignored while BUSY.
// - Handover: release -> IDLE (1 dead cycle) -> next grant.
//   - Back-to-back grants to different owners are therefore separated by exactly 1 cycle with Valid=0.
// - S holds its last owner value in IDLE; consumers qualify S with Valid.
// - Simultaneous requests in IDLE: rotation order from ptr decides.
//   - After reset, ptr=0, so 4'b1111 grants 0, then 1, 2, 3, 0, ...
// - A single persistent requester is re-granted after every release; no lockout when others are idle.
// - Kerkesa bits are sampled only at the edge; glitches between edges have no effect.
// - Invariants: Leja is one-hot or zero; S == index(Leja) whenever Valid=1.
// CONFIGURATION
// - `define ARB_TIMEOUT_EN (hold watchdog):
//   - BUSY with hold_cnt==MAX_HOLD-1 and Kerkesa[S] still 1: next edge forces release (Leja=0, Valid=0, state=IDLE, ptr=S+1) and Timeout=1 for that one cycle.
//   - The owner must re-request and wait its turn.
//   - Voluntary release on the same edge counts as a normal release: Timeout stays 0.
//   - hold_cnt width = $clog2(MAX_HOLD); it saturates and never wraps.
// - Without the macro:
//   - No hold_cnt register.
//   - Timeout is tied to 0.
//   - A grant lasts for as long as the owner requests; MAX_HOLD is ignored.
// STRUCTURE
// - Shared package arbiter_pkg holds:
//   - FSM state constants ST_IDLE=1'b0, ST_BUSY=1'b1
//   - N_REQ=4, SEL_W=2
//   - function onehot2 (2-bit index -> 4-bit one-hot)
// - Sub-module rr_pick4: combinational rotate-priority picker.
//   - Inputs: req[3:0], ptr[1:0]. Outputs: any, idx[1:0].
//   - Used for both the IDLE decision and the bench's reference model.
// - Top level holds FSM, ptr, output registers and the optional hold_cnt.
// TESTING
// - Reset: drive Kerkesa=4'b1111 with Reset_n=0 for 3 cycles -> Leja=0, Valid=0, S=0, Timeout=0 throughout.
// - Single request: Kerkesa=4'b0100 -> 1 cycle later Leja=4'b0100, S=2; drop bit 2 -> next cycle Valid=0, ptr=3.
// - Rotation: Kerkesa=4'b1111, each owner releases after 2 cycles -> grant order 0,1,2,3,0, one Valid=0 gap between each.
// - Wrap/fairness: ptr=3, Kerkesa=4'b1001 -> grant to 3; after release -> grant to 0.
// - Reset mid-grant: owner 1 BUSY, Reset_n=0 for one edge -> Leja=0, ptr=0; then Kerkesa=4'b0011 -> grant 0.
// - ARB_TIMEOUT_EN, MAX_HOLD=4: Kerkesa=4'b0011 held -> owner 0 granted for 4 cycles, Timeout pulses 1 cycle, then owner 1 granted.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
package arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_st_e;

  function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/arbiter_4ne1_rr_pick4.sv
// Rotate-priority picker: first set request bit scanning ptr, ptr+1, ... mod 4.
module rr_pick4
  import arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan farthest offset first so the closest set bit to ptr wins last.
  always_comb begin
    any  = |req;
    idx  = ptr;
    cand = ptr;
    for (int k = N_REQ-1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/arbiter_4ne1.sv
// Round-robin arbiter for the shared 4:1 select path; grant held until release.
// Optional hold watchdog enabled by `define ARB_TIMEOUT_EN (limit MAX_HOLD cycles).
module arbiter_4ne1
  import arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [N_REQ-1:0] Kerkesa,
  output logic [N_REQ-1:0] Leja,
  output logic [SEL_W-1:0] S,
  output logic             Valid,
  output logic             Timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_chk
    $error("MAX_HOLD out of range 2..255");
  end

  arb_st_e          st, st_n;
  logic [SEL_W-1:0] ptr, ptr_n, s_n;
  logic             pk_any;
  logic [SEL_W-1:0] pk_idx;

  rr_pick4 u_pick (
    .req (Kerkesa),
    .ptr (ptr),
    .any (pk_any),
    .idx (pk_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_cnt, cnt_n;
  logic          to_q, to_n;
`endif

  always_comb begin
    st_n  = st;
    ptr_n = ptr;
    s_n   = S;
`ifdef ARB_TIMEOUT_EN
    cnt_n = hold_cnt;
    to_n  = 1'b0;
`endif
    case (st)
      ST_IDLE: begin
        if (pk_any) begin
          st_n = ST_BUSY;
          s_n  = pk_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_n = '0;
`endif
        end
      end
      default: begin
        if (!Kerkesa[S]) begin
          st_n  = ST_IDLE;
          ptr_n = S + SEL_W'(1);
        end
`ifdef ARB_TIMEOUT_EN
        // Forced release; counter only climbs to MAX_HOLD-1, so it never wraps.
        else if (hold_cnt == HW'(MAX_HOLD-1)) begin
          st_n  = ST_IDLE;
          ptr_n = S + SEL_W'(1);
          to_n  = 1'b1;
        end else begin
          cnt_n = hold_cnt + HW'(1);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      st  <= ST_IDLE;
      ptr <= '0;
      S   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      st  <= st_n;
      ptr <= ptr_n;
      S   <= s_n;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= cnt_n;
      to_q     <= to_n;
`endif
    end
  end

  // Grant derived from owner index keeps Leja one-hot and consistent with S.
  assign Valid = (st == ST_BUSY);
  assign Leja  = Valid ? onehot2(S) : '0;

`ifdef ARB_TIMEOUT_EN
  assign Timeout = to_q;
`else
  assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_4ne1.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_arbiter_4ne1;

  localparam int MH = 4;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] Kerkesa = 4'b1111;
  logic [3:0] Leja;
  logic [1:0] S;
  logic       Valid, Timeout;

  int n_cmp = 0;
  int n_err = 0;

  // model: owner -1 means idle
  int m_owner = -1, m_ptr = 0, m_s = 0, m_hold = 0;
  bit m_to = 1'b0;

  arbiter_4ne1 #(.MAX_HOLD(MH)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Kerkesa (Kerkesa),
    .Leja    (Leja),
    .S       (S),
    .Valid   (Valid),
    .Timeout (Timeout)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] k, input logic r);
    bit wd;
`ifdef ARB_TIMEOUT_EN
    wd = 1'b1;
`else
    wd = 1'b0;
`endif
    m_to = 1'b0;
    if (!r) begin
      m_owner = -1; m_ptr = 0; m_s = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      for (int j = 0; j < 4; j++) begin
        int c;
        c = (m_ptr + j) % 4;
        if (k[c]) begin
          m_owner = c; m_s = c; m_hold = 0;
          break;
        end
      end
    end else if (!k[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (wd && m_hold == MH-1) begin
      m_ptr = (m_owner + 1) % 4;
      m_owner = -1;
      m_to = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic tick(input logic [3:0] k, input logic r);
    Kerkesa = k;
    Reset_n = r;
    @(posedge Clock);
    model_step(k, r);
    #1;
    chk("leja",  Leja,    (m_owner < 0) ? 0 : (1 << m_owner));
    chk("s",     S,       m_s);
    chk("valid", Valid,   (m_owner < 0) ? 0 : 1);
    chk("tmo",   Timeout, m_to);
  endtask

  initial begin
    logic [3:0] k;
    // reset with all requesting
    for (int i = 0; i < 3; i++) begin
      tick(4'b1111, 1'b0);
      chk("rst_leja", Leja, 0);
      chk("rst_valid", Valid, 0);
      chk("rst_s", S, 0);
    end

    // single request, then release moves ptr to 3
    tick(4'b0100, 1'b1);
    chk("single_leja", Leja, 4'b0100);
    chk("single_s", S, 2);
    tick(4'b0000, 1'b1);
    chk("single_rel", Valid, 0);

    // wrap: ptr=3, 1001 -> owner 3, then owner 0
    tick(4'b1001, 1'b1);
    chk("wrap_s3", S, 3);
    tick(4'b0001, 1'b1);
    chk("wrap_gap", Valid, 0);
    tick(4'b0001, 1'b1);
    chk("wrap_s0", S, 0);
    tick(4'b0000, 1'b1);

    // reset mid-grant
    tick(4'b0000, 1'b0);
    tick(4'b0010, 1'b1);
    chk("mid_s1", S, 1);
    tick(4'b0010, 1'b1);
    tick(4'b1111, 1'b0);
    chk("mid_rst", Leja, 0);
    tick(4'b0011, 1'b1);
    chk("mid_s0", S, 0);
    tick(4'b0000, 1'b0);

    // rotation: each owner holds 2 cycles then drops its bit
    for (int n = 0; n < 5; n++) begin
      tick(4'b1111, 1'b1);
      chk("rot_owner", S, n % 4);
      chk("rot_valid", Valid, 1);
      tick(4'b1111, 1'b1);
      k = 4'b1111;
      k[n % 4] = 1'b0;
      tick(k, 1'b1);
      chk("rot_gap", Valid, 0);
    end

`ifdef ARB_TIMEOUT_EN
    tick(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(4'b0011, 1'b1);
      chk("wd_hold", Leja, 4'b0001);
    end
    tick(4'b0011, 1'b1);
    chk("wd_pulse", Timeout, 1);
    tick(4'b0011, 1'b1);
    chk("wd_next", S, 1);
    chk("wd_clear", Timeout, 0);
`endif

    // random traffic, biased so grants persist
    for (int i = 0; i < 600; i++) begin
      k = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 9) < 8) k[m_owner] = 1'b1;
      tick(k, ($urandom_range(0, 49) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
